// File: rtl/serial_alu_pkg.sv
// Shared types for the bit-serial ALU: opcodes, FSM states, carry-in constants.
// Optional flag logic is enabled with SERIAL_ALU_FLAGS_EN.
package serial_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_PASSA = 3'b101,
        OP_PASSB = 3'b110,
        OP_RSVD  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } alu_state_e;

    localparam logic SUB_CIN = 1'b1;
    localparam logic ADD_CIN = 1'b0;

    function automatic logic cin_for(input alu_op_e op);
        return (op == OP_SUB) ? SUB_CIN : ADD_CIN;
    endfunction

    function automatic logic is_arith(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// One-bit ALU slice: full adder for ADD/SUB plus the bitwise/pass operations.
module serial_alu_slice
    import serial_alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    cin,
    input  alu_op_e op,
    output logic    res,
    output logic    cout
);

    logic bx;
    logic sum;

    always_comb begin
        bx   = (op == OP_SUB) ? ~b : b;
        sum  = a ^ bx ^ cin;
        cout = (a & bx) | (cin & (a ^ bx));
        res  = a;
        unique case (op)
            OP_ADD,
            OP_SUB:   res = sum;
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_PASSB: res = b;
            default:  res = a;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU top: IDLE/RUN/DONE sequencer, bit counter, carry and flags.
// Define SERIAL_ALU_FLAGS_EN to implement o_carry and o_zero.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [2:0] i_op,
    input  logic       i_a_bit,
    input  logic       i_b_bit,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_shift,
    output logic       o_write,
    output logic       o_res_bit,
    output logic       o_carry,
    output logic       o_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    alu_state_e state_q;
    alu_state_e state_d;
    alu_op_e    op_q;
    alu_op_e    op_in;
    logic [CW-1:0] cnt_q;
    logic       carry_q;
    logic       res;
    logic       cout;
    logic       run;
    logic       accept;

    assign op_in  = alu_op_e'(i_op);
    assign run    = (state_q == RUN);
    assign accept = (state_q == IDLE) && i_start;

    serial_alu_slice u_slice (
        .a    (i_a_bit),
        .b    (i_b_bit),
        .cin  (carry_q),
        .op   (op_q),
        .res  (res),
        .cout (cout)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= op_in;
                cnt_q   <= '0;
                carry_q <= cin_for(op_in);
            end else if (run) begin
                // Hold at LAST so the counter never wraps inside an operation.
                if (cnt_q != LAST) cnt_q <= cnt_q + CW'(1);
                if (is_arith(op_q)) carry_q <= cout;
            end
        end
    end

`ifdef SERIAL_ALU_FLAGS_EN
    logic zero_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            zero_q <= 1'b0;
        end else if (accept) begin
            zero_q <= 1'b1;
        end else if (run) begin
            zero_q <= zero_q & ~res;
        end
    end

    assign o_carry = carry_q;
    assign o_zero  = zero_q;
`else
    assign o_carry = 1'b0;
    assign o_zero  = 1'b0;
`endif

    assign o_busy    = run;
    assign o_shift   = run;
    assign o_write   = run;
    assign o_done    = (state_q == DONE);
    assign o_res_bit = run & res;

endmodule

// File: tb/tb_serial_alu.sv
// Directed-vector bench for serial_alu (WIDTH=8).
module tb_serial_alu;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic [2:0] i_op;
    logic       i_a_bit;
    logic       i_b_bit;
    logic       o_busy;
    logic       o_done;
    logic       o_shift;
    logic       o_write;
    logic       o_res_bit;
    logic       o_carry;
    logic       o_zero;

    int n_vec = 0;
    int n_err = 0;
    int n_shift = 0;

    serial_alu #(.WIDTH(8)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_op      (i_op),
        .i_a_bit   (i_a_bit),
        .i_b_bit   (i_b_bit),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_shift   (o_shift),
        .o_write   (o_write),
        .o_res_bit (o_res_bit),
        .o_carry   (o_carry),
        .o_zero    (o_zero)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) if (o_shift) n_shift <= n_shift + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp, input logic ec,
                          input logic ez);
        logic [7:0] r;
        int bad;
        int s0;
        bad = 0;
        r = '0;
        @(negedge i_clk);
        i_op = op;
        i_start = 1'b1;
        i_a_bit = 1'b0;
        i_b_bit = 1'b0;
        @(negedge i_clk);
        i_start = 1'b0;
        i_op = ~op;
        s0 = n_shift;
        for (int k = 0; k < 8; k++) begin
            i_a_bit = a[k];
            i_b_bit = b[k];
            #1;
            r[k] = o_res_bit;
            if (!(o_busy && o_shift && o_write) || o_done) bad++;
            @(negedge i_clk);
        end
        #1;
        chk({tag, " res"}, r, exp);
        chk({tag, " run_strobes"}, bad, 0);
        chk({tag, " shifts"}, n_shift - s0, 8);
        chk({tag, " done"}, {o_done, o_busy, o_shift, o_res_bit}, 4'b1000);
`ifdef SERIAL_ALU_FLAGS_EN
        chk({tag, " carry"}, o_carry, ec);
        chk({tag, " zero"}, o_zero, ez);
`else
        chk({tag, " carry"}, o_carry, 1'b0);
        chk({tag, " zero"}, o_zero, 1'b0);
        if (ec === 1'bx || ez === 1'bx) n_err++;
`endif
        @(negedge i_clk);
        #1;
        chk({tag, " idle"}, {o_done, o_busy}, 2'b00);
    endtask

    initial begin
        int rises;
        int first;
        int second;
        int dones;
        int viol;
        int s0;
        logic prev;

        i_rst = 1'b0;
        i_start = 1'b0;
        i_op = 3'b000;
        i_a_bit = 1'b0;
        i_b_bit = 1'b0;
        #12;
        chk("reset outs",
            {o_busy, o_done, o_shift, o_write, o_res_bit, o_carry, o_zero},
            7'b0);
        @(negedge i_clk);
        i_rst = 1'b1;

        run_op("add1", 3'b000, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0);
        run_op("add2", 3'b000, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
        run_op("sub1", 3'b001, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1);
        run_op("sub2", 3'b001, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
        run_op("sub3", 3'b001, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0);
        run_op("and",  3'b010, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0);
        run_op("or",   3'b011, 8'hCC, 8'hAA, 8'hEE, 1'b0, 1'b0);
        run_op("xor",  3'b100, 8'hF0, 8'hAA, 8'h5A, 1'b0, 1'b0);
        run_op("passb", 3'b110, 8'h33, 8'hA5, 8'hA5, 1'b0, 1'b0);
        run_op("rsvd", 3'b111, 8'h33, 8'h0F, 8'h33, 1'b0, 1'b0);

        // start held high: back-to-back acceptance
        @(negedge i_clk);
        i_op = 3'b000;
        i_a_bit = 1'b0;
        i_b_bit = 1'b0;
        i_start = 1'b1;
        rises = 0;
        first = -1;
        second = -1;
        dones = 0;
        viol = 0;
        prev = 1'b0;
        s0 = n_shift;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (o_busy && !prev) begin
                rises++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            prev = o_busy;
            if (o_done) dones++;
            if (o_shift !== o_busy || o_write !== o_busy) viol++;
            @(negedge i_clk);
        end
        i_start = 1'b0;
        chk("hold accepts", rises, 2);
        chk("hold first", first, 1);
        chk("hold spacing", second - first, 10);
        chk("hold dones", dones, 2);
        chk("hold strobes", viol, 0);
        chk("hold shifts", n_shift - s0, 16);

        // async reset in RUN cycle 4
        @(negedge i_clk);
        i_op = 3'b000;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge i_clk);
        #1;
        chk("rst pre shift", o_shift, 1'b1);
        i_rst = 1'b0;
        #1;
        chk("rst shift drop", {o_shift, o_write, o_busy}, 3'b000);
        @(negedge i_clk);
        i_rst = 1'b1;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (o_done || o_busy) dones++;
            @(negedge i_clk);
        end
        chk("rst no done", dones, 0);
        run_op("add_post", 3'b000, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got hang, want finish");
        $fatal(1);
    end

endmodule

// File: doc/serial_alu.md
# serial_alu

Bit-serial ALU that sits directly downstream of the two-register serial GPR file and closes the loop back into it. It consumes one operand bit per cycle from each register's LSB, computes one result bit per cycle LSB-first, and issues the shift/write strobes that push the result back into the GPR's MSB. A start/done handshake sequences exactly WIDTH bit-cycles per operation. Optional carry and zero flags are produced for the control unit.

## Interface
- WIDTH, 8: operand width in bits, which equals the number of bit-cycles per operation; legal range is 2 to 32.
- i_clk  in  1  sole clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-low reset (asserted when 0).
- i_start  in  1  start request; sampled only in IDLE.
- i_op  in  3  operation code (alu_op_e); latched on an accepted start.
- i_a_bit  in  1  operand A bit for the current cycle (GPR rx LSB).
- i_b_bit  in  1  operand B bit for the current cycle (GPR ry LSB).
- o_busy  out  1  high in RUN.
- o_done  out  1  one-cycle pulse in DONE.
- o_shift  out  1  shift strobe to the GPR; high in every RUN cycle.
- o_write  out  1  write enable to the GPR; high in every RUN cycle.
- o_res_bit  out  1  result bit for the current cycle, which becomes the GPR serial data in.
- o_carry  out  1  final carry/no-borrow; valid from DONE until the next accepted start.
- o_zero  out  1  high if every result bit of the last operation was 0.

## Operation
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A+~B+1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 PASSA.
  - 110 PASSB.
  - 111 is reserved and executes as PASSA.
- FSM states IDLE, RUN, DONE:
  - IDLE → RUN on i_start=1. On that edge: latch op, clear bit counter to 0, set zero accumulator to 1, load carry register (1 for SUB, 0 otherwise).
  - RUN: each cycle, o_res_bit is combinational from i_a_bit, i_b_bit, the carry register and the latched op. On the edge: carry ← full-adder carry-out (ADD/SUB only, otherwise unchanged); zero ← zero & ~o_res_bit; counter increments. When counter == WIDTH-1, go to DONE.
  - DONE → IDLE unconditionally after one cycle.
- Bit order is LSB-first. After WIDTH shifts the GPR holds the full result with bit 0 at its LSB.
- i_start is ignored in RUN and DONE. There is no queuing, and a request held high through DONE is accepted in the following IDLE cycle.
- i_op changes after acceptance have no effect.
- SUB carry semantics: o_carry=1 means no borrow (A ≥ B unsigned).
- Counter width is $clog2(WIDTH); it never wraps within an operation.

## Timing
- Reset values: state IDLE, counter 0, carry 0, zero 0. o_busy, o_done, o_shift and o_write are all 0. o_res_bit is 0 in IDLE and DONE (gated).
- Latency: start accepted at edge 0 → RUN for edges 1..WIDTH → o_done high for one cycle → IDLE. The next start can be accepted WIDTH+2 cycles after the previous one.
- Reset asserted mid-RUN: o_shift and o_write drop immediately (asynchronously). The GPR is left with a partially shifted value, and no o_done is produced.
- o_shift and o_write are asserted in exactly WIDTH consecutive cycles per operation, never outside RUN.

## Configuration
- SERIAL_ALU_FLAGS_EN defined: the carry-out register, zero accumulator, o_carry and o_zero are implemented as described.
- SERIAL_ALU_FLAGS_EN undefined: o_carry and o_zero are tied to 0 and the flag registers are removed. The internal carry for ADD/SUB is still kept, so results are unchanged.

## Structure
- serial_alu_pkg holds:
  - alu_op_e (3-bit enum with the codes above).
  - alu_state_e (IDLE, RUN, DONE).
  - localparams for the SUB carry-in value.
- One combinational sub-module, serial_alu_slice, takes a, b, cin and op and returns res and cout. serial_alu instantiates it once and owns the FSM, counter and flag registers.

## Test plan
- ADD, A=0x5A, B=0x3C, WIDTH=8 → result 0x96, o_carry=0, o_zero=0, o_done on cycle 9.
- ADD, A=0xFF, B=0x01 → result 0x00, o_carry=1, o_zero=1.
- SUB, A=0x10, B=0x10 → result 0x00, o_carry=1, o_zero=1. SUB, A=0x05, B=0x07 → result 0xFE, o_carry=0.
- XOR, A=0xF0, B=0xAA → 0x5A. Opcode 111, A=0x33 → 0x33. Exactly 8 o_shift pulses in each case.
- i_start held high for 20 cycles with ADD → two operations are accepted, 10 cycles apart, with no strobes during DONE or IDLE.
- i_rst pulsed low during RUN cycle 4 → o_shift drops the same cycle, state is IDLE, no o_done, and a new ADD then completes correctly.
